noc_router_node: RTL and testbench
==================================

Name: noc_router_node

Overview:
- Parametrised single-input, multi-output NoC router node: successor to the fixed 13-bit, single-channel NoC top.
- Accepts packets over a valid/ready handshake and buffers them in an internal FIFO.
- Decodes a destination field from the packet header and forwards each packet to exactly one of NUM_PORTS output channels using a per-port valid/ack handshake.
- Sits between a traffic source (NI or upstream router) and downstream routers or sinks.

Parameters:
- PKT_W, 13, total packet width in bits.
- DEST_W, 2, destination field width; field is in_packet[PKT_W-1 -: DEST_W].
- NUM_PORTS, 4, number of output channels; must be 1..2**DEST_W.
- FIFO_DEPTH, 4, input buffer depth in packets; power of two, ≥2.
- CNT_W, 16, statistics counter width (used only with NOC_STATS_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_packet  input  PKT_W  incoming packet.
- in_valid  input  1  in_packet valid.
- in_ready  output  1  node can accept; equals !fifo_full.
- out_packet  output  PKT_W  packet being forwarded; shared by all ports.
- out_valid  output  NUM_PORTS  one-hot; bit d high = packet offered to port d.
- out_ack  input  NUM_PORTS  per-port acceptance from downstream.
- busy  output  1  FSM not in IDLE, or FIFO non-empty.
- drop_pulse  output  1  one-cycle pulse when a packet with an invalid destination is discarded.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Clock/reset: single clock clk; reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: FIFO empty; fifo_count=0; in_ready=1 from the first cycle after reset; out_valid=0; out_packet=0; drop_pulse=0; busy=0; FSM=IDLE.
- Reset mid-operation: any buffered or in-flight packet is discarded with no ack or drop indication.
- Ingress:
  - Push on a rising edge with in_valid && in_ready.
  - in_valid while in_ready=0 is ignored; the source must hold the packet.
- FIFO:
  - Circular buffer; read/write pointers wrap at FIFO_DEPTH.
  - Push and pop on the same edge leave fifo_count unchanged.
  - Push when full cannot occur (in_ready gates it).
  - Pop when empty never occurs (FSM gates it).
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into hold register pkt_q and go to DECODE; otherwise stay.
  - DECODE: dest = pkt_q[PKT_W-1 -: DEST_W].
    - dest ≥ NUM_PORTS: assert drop_pulse for exactly one cycle (the cycle after this edge), return to IDLE.
    - Otherwise: latch dest, go to ROUTE.
  - ROUTE: out_valid[dest]=1, all other out_valid bits 0, out_packet=pkt_q.
    - Hold both stable until an edge with out_ack[dest]=1, then go to IDLE; out_valid clears in the following cycle.
- Acks on unselected ports, or while out_valid=0, are ignored.
- Ordering: packets leave in arrival order; no reordering; head-of-line blocking is accepted.
- Latency:
  - Push edge E into an empty, idle node → out_valid high in the cycle after edge E+2.
  - With an immediate ack, steady-state throughput is one packet per 3 cycles.
- out_packet holds its last value outside ROUTE (zero after reset).

Optional Feature:
- Macro: NOC_STATS_EN.
- Defined: adds output fwd_count (NUM_PORTS*CNT_W bits; port d at bits [d*CNT_W +: CNT_W]) and output drop_count (CNT_W bits).
  - fwd_count[d] increments on each ack edge for port d.
  - drop_count increments with each drop_pulse.
  - Counters saturate at all-ones, never wrap, and clear on reset.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then single packet 13'b10_000_0000_0101 (dest=2), out_ack[2] tied high → out_valid=4'b0100 in the cycle after push edge+2, out_packet=13'h1005, fifo_count back to 0, busy=0 after.
- Fill: 5 pushes with all out_ack=0, dest=1 → first packet moves to pkt_q; fifo_count reaches 4 with in_ready=0; 6th push held; release out_ack[1] → all 5 exit in order with unchanged payloads, in_ready returns to 1.
- Invalid destination with NUM_PORTS=3, dest=3 → drop_pulse high for exactly 1 cycle, all out_valid stay 0, next packet (dest=0) forwarded normally.
- Wrong-port ack: packet to dest=0, pulse out_ack[3] for 5 cycles → out_valid[0] stays high and out_packet stable; out_ack[0] then completes the transfer.
- Reset asserted while in ROUTE with 3 packets buffered → next cycle out_valid=0, fifo_count=0, in_ready=1, no drop_pulse.
- With NOC_STATS_EN, CNT_W=2: forward 5 packets to port 1 and drop 1 → fwd_count[1]=3 (saturated), drop_count=1, other fwd_count fields 0.

Source files
------------

// File: rtl/noc_router_node.sv
// rtl/noc_router_node.sv - single-input, NUM_PORTS-output NoC router node with input FIFO
//
// Purpose: buffers incoming packets in a FIFO_DEPTH-entry circular buffer, decodes
// the destination field from the top DEST_W bits of each packet, and offers it
// to exactly one output port over a valid/ack handshake. Packets whose
// destination is not a real port are discarded with a one-cycle drop_pulse.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_packet   incoming packet (PKT_W bits)
//   in_valid    in_packet valid
//   in_ready    node can accept a packet (FIFO not full)
//   out_packet  packet being forwarded, shared by all ports
//   out_valid   one-hot per-port offer
//   out_ack     per-port acceptance from downstream
//   busy        FSM not idle or FIFO non-empty
//   drop_pulse  one-cycle pulse when an invalid-destination packet is discarded
//   fifo_count  current FIFO occupancy
//   fwd_count   (NOC_STATS_EN only) per-port saturating forward counters
//   drop_count  (NOC_STATS_EN only) saturating drop counter
//
// Optional feature macro: NOC_STATS_EN adds the fwd_count/drop_count statistics.

module noc_router_node #(
  parameter int PKT_W      = 13,
  parameter int DEST_W     = 2,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PKT_W-1:0]                 in_packet,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [PKT_W-1:0]                 out_packet,
  output logic [NUM_PORTS-1:0]             out_valid,
  input  logic [NUM_PORTS-1:0]             out_ack,
  output logic                             busy,
  output logic                             drop_pulse,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
`ifdef NOC_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0]       fwd_count,
  output logic [CNT_W-1:0]                 drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  if (NUM_PORTS < 1 || NUM_PORTS > 2**DEST_W || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1 || DEST_W > PKT_W) begin : g_bad_params
    $error("noc_router_node: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, DECODE, ROUTE} state_t;

  logic [PKT_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  state_t            state, state_nxt;
  logic [PKT_W-1:0]  pkt_q;
  logic [PKT_W-1:0]  out_pkt_q;
  logic [DEST_W-1:0] dest_q;
  logic              drop_q;
  logic [DEST_W-1:0] dest;
  logic              dest_bad;
  logic              push, pop, ack_sel;

  assign in_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign dest       = pkt_q[PKT_W-1 -: DEST_W];
  assign dest_bad   = (32'(dest) >= NUM_PORTS);
  assign ack_sel    = |(out_valid & out_ack);
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;
  assign drop_pulse = drop_q;
  assign out_packet = out_pkt_q;

  // Storage is not reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_packet;
  end

  // Pointers are AW bits wide, so they wrap at FIFO_DEPTH naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = DECODE;
      DECODE:  state_nxt = dest_bad ? IDLE : ROUTE;
      ROUTE:   if (ack_sel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      out_valid[i] = (state == ROUTE) && (dest_q == DEST_W'(i));
    end
  end

  // out_pkt_q is a separate register so out_packet only changes on entry to
  // ROUTE and holds its last value while the next packet is popped and decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pkt_q     <= '0;
      out_pkt_q <= '0;
      dest_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      drop_q <= (state == DECODE) && dest_bad;
      if (pop) pkt_q <= mem[rd_ptr];
      if (state == DECODE && !dest_bad) begin
        dest_q    <= dest;
        out_pkt_q <= pkt_q;
      end
    end
  end

`ifdef NOC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_count  <= '0;
      drop_count <= '0;
    end else begin
      for (int d = 0; d < NUM_PORTS; d++) begin
        if (out_valid[d] && out_ack[d] && fwd_count[d*CNT_W +: CNT_W] != '1)
          fwd_count[d*CNT_W +: CNT_W] <= fwd_count[d*CNT_W +: CNT_W] + CNT_W'(1);
      end
      if (drop_q && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_noc_router_node.sv
// tb/tb_noc_router_node.sv - self-checking bench for noc_router_node

module tb_noc_router_node;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [12:0] in_packet;
  logic        in_valid, in_ready;
  logic [12:0] out_packet;
  logic [3:0]  out_valid, out_ack;
  logic        busy, drop_pulse;
  logic [2:0]  fifo_count;

  logic        in_valid3, in_ready3;
  logic [12:0] out_packet3;
  logic [2:0]  out_valid3, out_ack3;
  logic        busy3, drop3;
  logic [2:0]  fifo_count3;
`ifdef NOC_STATS_EN
  logic [7:0]  fwd4;
  logic [1:0]  dropc4;
  logic [5:0]  fwd3;
  logic [1:0]  dropc3;
`endif

  noc_router_node #(.NUM_PORTS(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .in_packet(in_packet), .in_valid(in_valid),
    .in_ready(in_ready), .out_packet(out_packet), .out_valid(out_valid),
    .out_ack(out_ack), .busy(busy), .drop_pulse(drop_pulse), .fifo_count(fifo_count)
`ifdef NOC_STATS_EN
    , .fwd_count(fwd4), .drop_count(dropc4)
`endif
  );

  noc_router_node #(.NUM_PORTS(3), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset), .in_packet(in_packet), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_packet(out_packet3), .out_valid(out_valid3),
    .out_ack(out_ack3), .busy(busy3), .drop_pulse(drop3), .fifo_count(fifo_count3)
`ifdef NOC_STATS_EN
    , .fwd_count(fwd3), .drop_count(dropc3)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct { logic [3:0] valid; logic [12:0] pkt; } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  typedef struct {
    logic [12:0] pkt;
    logic [3:0]  ack;
    logic [3:0]  exp_valid;
    logic [12:0] exp_pkt;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each completed handshake on the 4-port node must match the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (out_valid & out_ack) != 4'b0) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        sb_e = sb.pop_front();
        chk("sb_valid", 32'(out_valid), 32'(sb_e.valid));
        chk("sb_pkt", 32'(out_packet), 32'(sb_e.pkt));
      end
    end
  end

  task automatic send(input logic [12:0] p);
    logic ok = 1'b0;
    in_packet = p;
    in_valid  = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
    if (ok) sb.push_back('{4'b0001 << p[12:11], p});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    @(negedge clk);
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic send3(input logic [12:0] p);
    in_packet = p;
    in_valid3 = 1'b1;
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    int drops, dpos;
    logic [2:0] vseen;

    vecs[0] = '{13'h1005, 4'b0100, 4'b0100, 13'h1005};
    vecs[1] = '{13'h0000, 4'b1111, 4'b0001, 13'h0000};
    vecs[2] = '{13'h1FFF, 4'b1000, 4'b1000, 13'h1FFF};
    vecs[3] = '{13'h0AAA, 4'b0010, 4'b0010, 13'h0AAA};
    vecs[4] = '{13'h1555, 4'b0100, 4'b0100, 13'h1555};

    reset = 1'b1; in_valid = 1'b0; in_valid3 = 1'b0; in_packet = '0;
    out_ack = 4'b0; out_ack3 = 3'b111;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_packet", 32'(out_packet), 32'd0);
    chk("rst_drop", 32'(drop_pulse), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);

    // Single-packet latency and routing vectors.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      out_ack   = vecs[i].ack;
      in_packet = vecs[i].pkt;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back('{vecs[i].exp_valid, vecs[i].exp_pkt});
      @(negedge clk);
      chk("lat_e0_valid", 32'(out_valid), 32'd0);
      chk("lat_e0_count", 32'(fifo_count), 32'd1);
      @(negedge clk);
      chk("lat_e1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_e2_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
      chk("lat_e2_pkt", 32'(out_packet), 32'(vecs[i].exp_pkt));
      @(negedge clk);
      chk("post_valid", 32'(out_valid), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_count", 32'(fifo_count), 32'd0);
      chk("post_pkt_hold", 32'(out_packet), 32'(vecs[i].exp_pkt));
    end
    @(posedge clk); #1 out_ack = 4'b0;

    // Fill the FIFO behind a blocked port, hold a sixth packet, then drain.
    for (int i = 0; i < 5; i++) send(13'(13'h0800 + i));
    @(negedge clk);
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_valid", 32'(out_valid), 32'b0010);
    chk("fill_pkt", 32'(out_packet), 32'h0800);
    in_packet = 13'h0805;
    in_valid  = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_count", 32'(fifo_count), 32'd4);
    chk("held_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 out_ack = 4'b0010;
    send(13'h0805);
    wait_idle();
    chk("fill_sb_empty", 32'(sb.size()), 32'd0);
    chk("fill_in_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1 out_ack = 4'b0;

    // Acks on a non-selected port must not complete the transfer.
    send(13'h0123);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 out_ack = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wp_valid", 32'(out_valid), 32'b0001);
      chk("wp_pkt", 32'(out_packet), 32'h0123);
    end
    @(posedge clk); #1 out_ack = 4'b0001;
    wait_idle();
    chk("wp_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1 out_ack = 4'b0;

    // Reset while routing with three packets buffered.
    for (int i = 0; i < 4; i++) send(13'(13'h1800 + i));
    @(negedge clk);
    chk("rr_pre_count", 32'(fifo_count), 32'd3);
    chk("rr_pre_valid", 32'(out_valid), 32'b1000);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rr_valid", 32'(out_valid), 32'd0);
    chk("rr_count", 32'(fifo_count), 32'd0);
    chk("rr_in_ready", 32'(in_ready), 32'd1);
    chk("rr_busy", 32'(busy), 32'd0);
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      drops += int'(drop_pulse);
      @(negedge clk);
    end
    chk("rr_no_drop", 32'(drops), 32'd0);

    // Three-port node: destination 3 is discarded.
    send3(13'h183C);
    drops = 0; dpos = -1; vseen = 3'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (drop3) begin drops++; dpos = k; end
      vseen |= out_valid3;
    end
    chk("drop_pulses", 32'(drops), 32'd1);
    chk("drop_pos", 32'(dpos), 32'd2);
    chk("drop_no_valid", 32'(vseen), 32'd0);

    for (int i = 0; i < 5; i++) begin
      send3(13'(13'h0810 + i));
      repeat (3) @(negedge clk);
      chk("p1_valid", 32'(out_valid3), 32'b010);
      chk("p1_pkt", 32'(out_packet3), 32'(13'h0810 + i));
      @(negedge clk);
    end
`ifdef NOC_STATS_EN
    chk("stat_fwd1", 32'(fwd3[3:2]), 32'd3);
    chk("stat_fwd0", 32'(fwd3[1:0]), 32'd0);
    chk("stat_fwd2", 32'(fwd3[5:4]), 32'd0);
    chk("stat_drop", 32'(dropc3), 32'd1);
`endif

    send3(13'h0055);
    repeat (3) @(negedge clk);
    chk("after_drop_valid", 32'(out_valid3), 32'b001);
    chk("after_drop_pkt", 32'(out_packet3), 32'h0055);
    @(negedge clk);
    chk("after_drop_idle", 32'(busy3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
